// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: screen mode, level, lives and BCD score
// bookkeeping, with frame-counted dwell on intro and end screens.
module game_flow_ctrl #(
    parameter int NUM_LEVELS   = 5,
    parameter int LIVES        = 3,
    parameter int INBET_FRAMES = 120,
    parameter int END_FRAMES   = 180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        on_sw,
    input  logic        vsync,
    input  logic        start_btn,
    input  logic        player_hit,
    input  logic        level_clear,
    input  logic        score_inc,
    input  logic [3:0]  score_pts,
    output logic [2:0]  mode,
    output logic [2:0]  level,
    output logic [11:0] score,
    output logic [1:0]  lives,
    output logic        game_run,
    output logic        level_load
);

    typedef enum logic [2:0] {
        TITLE = 3'b000,
        GAME  = 3'b001,
        INTRO = 3'b010,
        WIN   = 3'b011,
        OVER  = 3'b100
    } state_e;

    localparam logic [2:0] LVL_LAST   = 3'(NUM_LEVELS);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] INBET_LIM  = 8'(INBET_FRAMES);
    localparam logic [7:0] END_LIM    = 8'(END_FRAMES);

    state_e      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [2:0]  level_q, level_d;
    logic [11:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        game_run_q, game_run_d;
    logic        level_load_q, level_load_d;
    logic        vsync_q, vsync_d;
    logic        start_s1_q, start_s1_d;
    logic        start_s2_q, start_s2_d;
    logic        start_s3_q, start_s3_d;
    logic        start_evt_q, start_evt_d;
    logic        frame_tick;
    logic [7:0]  cnt_inc;

    // Three-digit BCD add that saturates at 999; points above 9 clamp to 9.
    function automatic logic [11:0] bcd_add(input logic [11:0] s,
                                            input logic [3:0]  p);
        logic [3:0] pp;
        logic [4:0] o, t, h;
        pp = (p > 4'd9) ? 4'd9 : p;
        o  = {1'b0, s[3:0]} + {1'b0, pp};
        t  = {1'b0, s[7:4]};
        h  = {1'b0, s[11:8]};
        if (o > 5'd9) begin
            o = o - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9) begin
            t = t - 5'd10;
            h = h + 5'd1;
        end
        if (h > 5'd9) return 12'h999;
        return {h[3:0], t[3:0], o[3:0]};
    endfunction

    always_comb begin
        vsync_d     = vsync;
        start_s1_d  = start_btn;
        start_s2_d  = start_s1_q;
        start_s3_d  = start_s2_q;
        start_evt_d = start_s2_q & ~start_s3_q;
    end

    assign frame_tick = vsync_q & ~vsync;
    assign cnt_inc    = frame_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        level_d      = level_q;
        score_d      = score_q;
        lives_d      = lives_q;
        level_load_d = 1'b0;

        if (!on_sw) begin
            state_d     = TITLE;
            frame_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                TITLE: begin
                    if (start_evt_q) begin
                        level_d      = 3'd1;
                        score_d      = 12'h000;
                        lives_d      = LIVES_INIT;
                        frame_cnt_d  = 8'd0;
                        level_load_d = 1'b1;
                        state_d      = INTRO;
                    end
                end
                INTRO: begin
                    if (frame_tick) begin
                        frame_cnt_d = cnt_inc;
                        if (cnt_inc == INBET_LIM) begin
                            frame_cnt_d = 8'd0;
                            state_d     = GAME;
                        end
                    end
                end
                GAME: begin
                    if (score_inc) score_d = bcd_add(score_q, score_pts);
                    // A fatal hit wins over a same-cycle level clear.
                    if (player_hit && lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end else begin
                        if (player_hit) lives_d = lives_q - 2'd1;
                        if (level_clear) begin
                            if (level_q == LVL_LAST) begin
                                state_d = WIN;
                            end else begin
                                level_d      = level_q + 3'd1;
                                frame_cnt_d  = 8'd0;
                                level_load_d = 1'b1;
                                state_d      = INTRO;
                            end
                        end
                    end
                end
                WIN, OVER: begin
                    if (frame_tick) begin
                        frame_cnt_d = cnt_inc;
                        if (cnt_inc == END_LIM) begin
                            frame_cnt_d = 8'd0;
                            state_d     = TITLE;
                        end
                    end
                end
                default: begin
                    state_d     = TITLE;
                    frame_cnt_d = 8'd0;
                end
            endcase
        end

        game_run_d = (state_d == GAME);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TITLE;
            frame_cnt_q  <= 8'd0;
            level_q      <= 3'd1;
            score_q      <= 12'h000;
            lives_q      <= LIVES_INIT;
            game_run_q   <= 1'b0;
            level_load_q <= 1'b0;
            vsync_q      <= 1'b1;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_s3_q   <= 1'b0;
            start_evt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            level_q      <= level_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            game_run_q   <= game_run_d;
            level_load_q <= level_load_d;
            vsync_q      <= vsync_d;
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_s3_q   <= start_s3_d;
            start_evt_q  <= start_evt_d;
        end
    end

    assign mode       = state_q;
    assign level      = level_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_run   = game_run_q;
    assign level_load = level_load_q;

endmodule
